mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-beat memory port (ce/we/addr/data/ready, served by the AXI memory bridge) among NUM_REQ requesters.
//  Round-robin, one transaction in flight; grant held from issue until downstream ready, then one idle (ce=0) cycle so the bridge FSM returns to free.
//  Per-request watchdog aborts hung transactions and flags the requester. Sits between core-side masters (fetch, data, DMA) and the bridge.
// PARAMETERS
//  NUM_REQ   2   number of requesters (2..8); index 0 wins first after reset
//  ADDR_W   32   address width (ADDR_BUS)
//  DATA_W   32   data width (DATA_BUS)
//  TIMEOUT 256   max BUSY cycles before abort; 0 disables the watchdog
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset, synchronous, active-high
//  req_ce_i     in   NUM_REQ          per-requester request valid, held until its ready/err
//  req_we_i     in   NUM_REQ          1=write, 0=read
//  req_addr_i   in   NUM_REQ*ADDR_W   packed addresses, slot i at [i*ADDR_W +: ADDR_W]
//  req_data_i   in   NUM_REQ*DATA_W   packed write data
//  req_data_o   out  DATA_W           read data, valid with req_ready_o
//  req_ready_o  out  NUM_REQ          one-hot completion pulse
//  req_err_o    out  NUM_REQ          one-hot timeout-abort pulse
//  grant_o      out  NUM_REQ          one-hot current owner (0 when not BUSY)
//  mem_ce_o     out  1                downstream enable
//  mem_we_o     out  1                downstream write
//  mem_addr_o   out  ADDR_W           downstream address (registered at grant)
//  mem_data_o   out  DATA_W           downstream write data (registered at grant)
//  mem_data_i   in   DATA_W           downstream read data
//  mem_ready_i  in   1                downstream completion
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=NUM_REQ-1, grant_o=0, mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, counter=0;
//    combinational outputs forced 0 while state!=BUSY. Reset mid-transaction drops mem_ce_o next edge; request lost.
//  - States IDLE, BUSY, GAP. Arbitration in IDLE and GAP: first req_ce_i[j] set scanning j=ptr+1..ptr+NUM_REQ mod NUM_REQ.
//    In GAP the just-served index is masked (it may re-win only from IDLE or when another requester goes first).
//  - IDLE/GAP + winner j -> BUSY next edge: grant_o=1<<j, latch we/addr/data of j into mem_*_o, mem_ce_o=1, ptr=j, counter=0.
//    GAP with no winner -> IDLE. IDLE with no request -> stay. Request-to-mem_ce_o latency: 1 cycle.
//  - BUSY: mem_*_o stable. req_ready_o[j]=mem_ready_i, req_data_o=mem_data_i when !mem_we_o else 0 (combinational, zero added latency).
//    mem_ready_i=1 -> GAP, mem_ce_o=0 next edge. Back-to-back issue spacing: ready at cycle r, ce=0 at r+1, next ce=1 at r+2.
//  - Abort: req_ce_i[j] dropped while BUSY -> GAP, mem_ce_o=0; mem_ready_i in that cycle ignored (no req_ready_o).
//  - Watchdog: counter increments each BUSY cycle without ready; counter==TIMEOUT-1 and no ready -> req_err_o[j]=1 one cycle, -> GAP.
//    Ready and timeout same cycle: ready wins, no err. Counter width clog2(TIMEOUT+1), saturates, never wraps.
//  - Requesters other than owner see ready/err 0; their inputs are don't-care while not granted.
//  - Non-owner req changes in BUSY do not affect mem_*_o.
// TESTING
//  1 single read: req0 ce, addr 0x100, mem_ready_i at 3rd BUSY cycle, mem_data_i 0xDEADBEEF -> mem_ce_o high at t+1, req_ready_o=01, req_data_o=0xDEADBEEF, ce low next cycle.
//  2 contention: req0 and req1 both ce from reset, each ready after 2 cycles -> grants 01,10,01,10 alternating, one ce=0 cycle between each.
//  3 write: req1 we=1, addr 0x40, data 0x12345678 -> mem_we_o=1, mem_addr_o=0x40, mem_data_o=0x12345678 stable until ready; req_data_o=0.
//  4 timeout: TIMEOUT=8, never assert mem_ready_i -> req_err_o pulse in 8th BUSY cycle, GAP, no req_ready_o; ready+timeout same cycle -> ready only.
//  5 abort/reset: drop req0 ce in BUSY while mem_ready_i=1 -> no req_ready_o, ce low next edge; rst in BUSY -> all outputs 0 next edge, ptr restart gives req0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter that shares one single-beat memory port
//                (ce/we/addr/data/ready) among NUM_REQ requesters. One
//                transaction is in flight at a time. The grant is held from
//                issue until downstream ready (or abort/timeout). One idle
//                cycle (mem_ce_o=0) always follows, so the downstream bridge
//                can return to its free state. A per-transaction watchdog
//                aborts hung accesses and flags the owning requester.
//
//  Ports       :
//    clk, rst           clock, synchronous active-high reset
//    req_ce_i           per-requester request valid (held until ready/err)
//    req_we_i           per-requester write enable (1=write)
//    req_addr_i         packed addresses, slot i at [i*ADDR_W +: ADDR_W]
//    req_data_i         packed write data, slot i at [i*DATA_W +: DATA_W]
//    req_data_o         read data, valid with req_ready_o
//    req_ready_o        one-hot completion pulse to the owner
//    req_err_o          one-hot timeout-abort pulse to the owner
//    grant_o            one-hot current owner (0 when not BUSY)
//    mem_ce_o/mem_we_o  downstream enable / write
//    mem_addr_o         downstream address (registered at grant)
//    mem_data_o         downstream write data (registered at grant)
//    mem_data_i         downstream read data
//    mem_ready_i        downstream completion
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_ce_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        req_err_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i,
    input  logic                      mem_ready_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PTR_W:0]   C_NUM_EXT  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] C_PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [NUM_REQ-1:0] C_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q,   ptr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    // Unpacked views of the request buses, indexable by the winner index.
    logic [ADDR_W-1:0]   slot_addr [NUM_REQ];
    logic [DATA_W-1:0]   slot_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign slot_addr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
        assign slot_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last owner. In GAP the
    // requester that was just served is skipped so another waiting
    // requester always gets the next slot.
    // ------------------------------------------------------------------
    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W:0]      arb_sum;
    logic [PTR_W-1:0]    arb_cand;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (arb_sum >= C_NUM_EXT) begin
                arb_sum = arb_sum - C_NUM_EXT;
            end
            arb_cand = arb_sum[PTR_W-1:0];
            if (!win_valid && req_ce_i[arb_cand] &&
                !((state_q == GAP) && (arb_cand == ptr_q))) begin
                win_valid = 1'b1;
                win_idx   = arb_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner status while BUSY
    // ------------------------------------------------------------------
    logic                busy;
    logic                owner_ce;
    logic                timeout_hit;
    logic                done_ok;
    logic                abort_to;
    logic [NUM_REQ-1:0]  owner_oh;

    assign busy        = (state_q == BUSY);
    assign owner_ce    = req_ce_i[ptr_q];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == C_CNT_LAST);
    // Owner dropping its request masks a coincident ready; ready beats timeout.
    assign done_ok     = busy && owner_ce && mem_ready_i;
    assign abort_to    = busy && owner_ce && !mem_ready_i && timeout_hit;
    assign owner_oh    = C_ONE << ptr_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            IDLE, GAP: begin
                if (win_valid) begin
                    state_d = BUSY;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                    we_d    = req_we_i[win_idx];
                    addr_d  = slot_addr[win_idx];
                    data_d  = slot_data[win_idx];
                end else if (state_q == GAP) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!owner_ce || mem_ready_i || timeout_hit) begin
                    state_d = GAP;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= C_PTR_RST;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: requester-side responses are combinational from the
    // downstream port so completion adds no latency.
    // ------------------------------------------------------------------
    assign grant_o     = busy ? owner_oh : '0;
    assign req_ready_o = done_ok ? owner_oh : '0;
    assign req_err_o   = abort_to ? owner_oh : '0;
    assign req_data_o  = (busy && !we_q) ? mem_data_i : '0;

    assign mem_ce_o    = busy;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Directed scenarios for
//                single read, contention, write, watchdog, abort and reset,
//                followed by randomized traffic compared every cycle against
//                a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_ce;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [DW-1:0]     req_rdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_err;
    logic [N-1:0]      grant;
    logic              mem_ce;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_ce_i    (req_ce),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_data_o  (req_rdata),
        .req_ready_o (req_ready),
        .req_err_o   (req_err),
        .grant_o     (grant),
        .mem_ce_o    (mem_ce),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .mem_ready_i (mem_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] t;
        t    = '0;
        t[0] = 1'b1;
        return t << i;
    endfunction

    task automatic set_slot(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        if (we) req_we = req_we | onehot(i);
        else    req_we = req_we & ~onehot(i);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: who owns the port, how long it has
    // been waiting, who was served last and whether we are in the
    // mandatory idle cycle after a transaction.
    // ------------------------------------------------------------------
    bit            m_busy;
    bit            m_after;
    int            m_owner;
    int            m_last;
    int            m_age;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_done = '0;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_after = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_age   = 0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the
    // model at the rising edge, return 1 time unit after it.
    task automatic cycle();
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_rdy;
        logic [N-1:0]  e_err;
        logic [DW-1:0] e_rdata;
        bit            picked;
        int            j;
        @(negedge clk);
        e_grant = '0;
        e_rdy   = '0;
        e_err   = '0;
        e_rdata = '0;
        if (m_busy) begin
            e_grant = onehot(m_owner);
            if (bit_of(req_ce, m_owner)) begin
                if (mem_ready)           e_rdy = onehot(m_owner);
                else if (m_age == TO-1)  e_err = onehot(m_owner);
            end
            if (!m_we) e_rdata = mem_rdata;
        end
        check_eq("mem_ce",    32'(mem_ce),    32'(m_busy));
        check_eq("grant",     32'(grant),     32'(e_grant));
        check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
        check_eq("req_err",   32'(req_err),   32'(e_err));
        check_eq("req_data",  req_rdata,      e_rdata);
        if (m_busy) begin
            check_eq("mem_we",   32'(mem_we), 32'(m_we));
            check_eq("mem_addr", mem_addr,    m_addr);
            check_eq("mem_data", mem_wdata,   m_wdata);
        end
        m_done = e_rdy | e_err;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (!bit_of(req_ce, m_owner) || mem_ready || m_age == TO-1) begin
                m_busy  = 1'b0;
                m_after = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            picked = 1'b0;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!picked && bit_of(req_ce, j) && !(m_after && j == m_last)) begin
                    picked  = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = j;
                    m_last  = j;
                    m_age   = 0;
                    m_we    = bit_of(req_we, j);
                    m_addr  = req_addr[j*AW +: AW];
                    m_wdata = req_data[j*DW +: DW];
                end
            end
            m_after = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_ce    = '0;
        mem_ready = 1'b0;
        cycle();
        rst       = 1'b0;
    endtask

    task automatic rand_phase(input int cycles);
        bit pend [N];
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && bit_of(m_done, i)) begin
                    pend[i] = 1'b0;
                    req_ce  = req_ce & ~onehot(i);
                end else if (pend[i] && m_busy && m_owner == i && $urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                    req_ce  = req_ce & ~onehot(i);
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    set_slot(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
                    req_ce  = req_ce | onehot(i);
                end
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom();
            rst       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
    endtask

    int exp_grant [4] = '{1, 2, 1, 2};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        req_ce    = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        model_reset();
        cycle();
        cycle();
        check_eq("rst_grant",    32'(grant),     32'h0);
        check_eq("rst_mem_ce",   32'(mem_ce),    32'h0);
        check_eq("rst_mem_we",   32'(mem_we),    32'h0);
        check_eq("rst_mem_addr", mem_addr,       32'h0);
        check_eq("rst_mem_data", mem_wdata,      32'h0);
        rst = 1'b0;

        // Single read
        set_slot(0, 1'b0, 32'h100, 32'h0);
        req_ce = 2'b01;
        cycle();
        check_eq("t1_ce_high", 32'(mem_ce),   32'h1);
        check_eq("t1_addr",    mem_addr,      32'h100);
        cycle();
        cycle();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check_eq("t1_ready", 32'(req_ready), 32'h1);
        check_eq("t1_rdata", req_rdata,      32'hDEADBEEF);
        cycle();
        req_ce    = '0;
        mem_ready = 1'b0;
        check_eq("t1_ce_low", 32'(mem_ce), 32'h0);
        cycle();

        // Contention: alternating grants with an idle cycle between
        do_reset();
        set_slot(0, 1'b0, 32'h1000, 32'h0);
        set_slot(1, 1'b0, 32'h2000, 32'h0);
        req_ce = 2'b11;
        for (int t = 0; t < 4; t++) begin
            cycle();
            check_eq("t2_grant", 32'(grant), 32'(exp_grant[t]));
            cycle();
            mem_ready = 1'b1;
            cycle();
            mem_ready = 1'b0;
            check_eq("t2_gap", 32'(mem_ce), 32'h0);
        end

        // Write from requester 1, non-owner activity must not disturb it
        do_reset();
        set_slot(1, 1'b1, 32'h40, 32'h12345678);
        req_ce = 2'b10;
        cycle();
        check_eq("t3_grant", 32'(grant),  32'h2);
        check_eq("t3_we",    32'(mem_we), 32'h1);
        check_eq("t3_addr",  mem_addr,    32'h40);
        check_eq("t3_data",  mem_wdata,   32'h12345678);
        for (int b = 0; b < 3; b++) begin
            set_slot(0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            req_ce = {1'b1, 1'($urandom_range(0, 1))};
            cycle();
        end
        req_ce = 2'b10;
        check_eq("t3_addr_hold", mem_addr,  32'h40);
        check_eq("t3_data_hold", mem_wdata, 32'h12345678);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check_eq("t3_ready", 32'(req_ready), 32'h2);
        check_eq("t3_rdata", req_rdata,      32'h0);
        cycle();
        req_ce    = '0;
        mem_ready = 1'b0;
        cycle();

        // Watchdog: err pulse in 8th BUSY cycle, then ready beats timeout
        do_reset();
        set_slot(0, 1'b0, 32'h200, 32'h0);
        req_ce = 2'b01;
        cycle();
        for (int b = 0; b < TO - 1; b++) begin
            check_eq("t4_no_err_early", 32'(req_err), 32'h0);
            cycle();
        end
        check_eq("t4_err",      32'(req_err),   32'h1);
        check_eq("t4_no_ready", 32'(req_ready), 32'h0);
        cycle();
        req_ce = '0;
        check_eq("t4_ce_low", 32'(mem_ce), 32'h0);
        cycle();
        req_ce = 2'b01;
        cycle();
        for (int b = 0; b < TO - 1; b++) cycle();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        #1;
        check_eq("t4_ready_wins", 32'(req_ready), 32'h1);
        check_eq("t4_err_masked", 32'(req_err),   32'h0);
        cycle();
        req_ce    = '0;
        mem_ready = 1'b0;
        cycle();

        // Abort while ready is high, then reset mid-transaction
        do_reset();
        set_slot(0, 1'b0, 32'h300, 32'h0);
        req_ce = 2'b01;
        cycle();
        cycle();
        req_ce    = '0;
        mem_ready = 1'b1;
        #1;
        check_eq("t5_abort_no_ready", 32'(req_ready), 32'h0);
        cycle();
        mem_ready = 1'b0;
        check_eq("t5_abort_ce_low", 32'(mem_ce), 32'h0);
        cycle();
        set_slot(0, 1'b1, 32'h3C0, 32'hA5A5A5A5);
        set_slot(1, 1'b0, 32'h3F0, 32'h0);
        req_ce = 2'b01;
        cycle();
        check_eq("t5_busy0", 32'(grant), 32'h1);
        req_ce = 2'b11;
        rst    = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("t5_rst_ce",   32'(mem_ce),  32'h0);
        check_eq("t5_rst_gnt",  32'(grant),   32'h0);
        check_eq("t5_rst_we",   32'(mem_we),  32'h0);
        check_eq("t5_rst_addr", mem_addr,     32'h0);
        check_eq("t5_rst_data", mem_wdata,    32'h0);
        cycle();
        check_eq("t5_req0_first", 32'(grant), 32'h1);
        cycle();

        // Randomized traffic
        do_reset();
        rand_phase(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
